intersection_ctrl: RTL

Two-way intersection scheduler that sequences two traffic-light heads (main road A, side road B) and arbitrates the single green right-of-way between them. Main road holds green by default. A side-road vehicle sensor or a pedestrian `pass` request schedules a bounded A→B→A cycle with yellow and all-red clearance phases. Sits above per-head lamp drivers and drives their R/G/Y lines directly.

---
 rtl/intersection_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/intersection_ctrl.sv
// Two-head intersection scheduler: main road A holds green, side/ped requests buy one bounded A->B->A cycle.
// Optional pedestrian early-exit path enabled by PED_PASS_EN; lamps and phase registered, async reset forces A green.
module intersection_ctrl #(
  parameter int G_MIN   = 64,
  parameter int G_MAX   = 512,
  parameter int B_TIME  = 128,
  parameter int Y_TIME  = 32,
  parameter int AR_TIME = 8,
  parameter int CNT_W   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_b,
  input  logic       pass,
  output logic       a_R,
  output logic       a_G,
  output logic       a_Y,
  output logic       b_R,
  output logic       b_G,
  output logic       b_Y,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR1   = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR2   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(G_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(G_MAX - 1);
  localparam logic [CNT_W-1:0] B_LAST    = CNT_W'(B_TIME - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_TIME - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pend_v;
  logic             pend_p;
  logic [5:0]       lamps;

  // Lamp bundle order: {a_R, a_G, a_Y, b_R, b_G, b_Y}
  function automatic logic [5:0] lamps_of(input state_t s);
    logic [5:0] l;
    l = 6'b010_100;
    case (s)
      A_GRN:    l = 6'b010_100;
      A_YEL:    l = 6'b001_100;
      AR1, AR2: l = 6'b100_100;
      B_GRN:    l = 6'b100_010;
      B_YEL:    l = 6'b100_001;
      default:  l = 6'b010_100;
    endcase
    return l;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN: if ((pend_p && cnt >= GMIN_LAST) || (pend_v && cnt >= GMAX_LAST))
               state_nxt = A_YEL;
      A_YEL: if (cnt == Y_LAST)  state_nxt = AR1;
      AR1:   if (cnt == AR_LAST) state_nxt = B_GRN;
      B_GRN: if (cnt == B_LAST)  state_nxt = B_YEL;
      B_YEL: if (cnt == Y_LAST)  state_nxt = AR2;
      AR2:   if (cnt == AR_LAST) state_nxt = A_GRN;
      default: state_nxt = A_GRN;
    endcase
  end

`ifdef PED_PASS_EN
  logic pend_p_q;
  assign pend_p = pend_p_q;
`else
  logic unused_pass;
  assign unused_pass = pass;
  assign pend_p      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= A_GRN;
      cnt      <= '0;
      pend_v   <= 1'b0;
`ifdef PED_PASS_EN
      pend_p_q <= 1'b0;
`endif
      lamps    <= 6'b010_100;
    end else begin
      state <= state_nxt;
      lamps <= lamps_of(state_nxt);

      if (state_nxt != state)
        cnt <= '0;
      else if (!(state == A_GRN && cnt >= GMAX_LAST))
        cnt <= cnt + 1'b1;

      // Entering B green retires served requests; a request on that same edge survives.
      if (req_b)
        pend_v <= 1'b1;
      else if (state_nxt == B_GRN && state != B_GRN)
        pend_v <= 1'b0;
`ifdef PED_PASS_EN
      if (pass)
        pend_p_q <= 1'b1;
      else if (state_nxt == B_GRN && state != B_GRN)
        pend_p_q <= 1'b0;
`endif
    end
  end

  assign {a_R, a_G, a_Y, b_R, b_G, b_Y} = lamps;
  assign phase = state;

endmodule
